// File: rtl/wb_flash_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of the single NOR-flash Wishbone port.
// Master 0 is the QSPI control FSM and master 1 is the VT-scan/maintenance sequencer.
// Bus cycles (CYC high to CYC low) are granted whole and round-robin.
// The arbiter counts accepted-but-unacked requests and stalls the owner when the count reaches
// MAXINFLIGHT. If the slave stays silent for TIMEOUT cycles, the cycle is aborted with an error.
//
// Ports
//   clk_i, reset_ni                 clock, synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i [1:0]    per-master CYC/STB/WE, bit i = master i
//   m_adr_i, m_dat_i                per-master address / write data, master i at slice i
//   m_stall_o/m_ack_o/m_err_o [1:0] per-master STALL/ACK/ERR
//   m_dat_o                         shared read data (valid with m_ack_o)
//   s_cyc_o/s_stb_o/s_we_o          slave CYC/STB/WE
//   s_adr_o, s_dat_o                slave address / write data
//   s_ack_i/s_err_i/s_stall_i       slave ACK/ERR/STALL
//   s_dat_i                         slave read data
//   gnt_o                           one-hot current owner, 00 when idle
//   timeout_o                       one-cycle pulse when a hung cycle is aborted
//   spurious_o                      one-cycle pulse on ack/err with nothing outstanding
module wb_flash_arbiter #(
  parameter int unsigned ADDRBITS    = 26,
  parameter int unsigned DATABITS    = 16,
  parameter int unsigned MAXINFLIGHT = 16,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [1:0]            m_cyc_i,
  input  logic [1:0]            m_stb_i,
  input  logic [1:0]            m_we_i,
  input  logic [2*ADDRBITS-1:0] m_adr_i,
  input  logic [2*DATABITS-1:0] m_dat_i,
  output logic [1:0]            m_stall_o,
  output logic [1:0]            m_ack_o,
  output logic [1:0]            m_err_o,
  output logic [DATABITS-1:0]   m_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDRBITS-1:0]   s_adr_o,
  output logic [DATABITS-1:0]   s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_stall_i,
  input  logic [DATABITS-1:0]   s_dat_i,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o,
  output logic                  spurious_o
);

  localparam int unsigned CntW = $clog2(MAXINFLIGHT + 1);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAXINFLIGHT);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGnt, StAbort} state_e;

  state_e          state_q, state_d;
  logic            gnt_idx_q, gnt_idx_d;  // index of the owning master
  logic            last_q, last_d;        // master that owned the previous bus cycle
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [TmrW-1:0] timer_q, timer_d;

  logic       resp;
  logic       busy;
  logic       full;
  logic       accept;
  logic       dec;
  logic       expire;
  logic [1:0] gnt_oh;

  assign resp   = s_ack_i | s_err_i;
  assign busy   = (inflight_q != '0);
  assign full   = (inflight_q == MaxCnt);
  assign gnt_oh = gnt_idx_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_d     = last_q;
    inflight_d = inflight_q;
    m_stall_o  = 2'b11;
    m_ack_o    = 2'b00;
    m_err_o    = 2'b00;
    m_dat_o    = s_dat_i;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    gnt_o      = 2'b00;
    timeout_o  = 1'b0;
    accept     = 1'b0;
    dec        = 1'b0;
    expire     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|m_cyc_i) begin
          state_d = StGnt;
          // Contention goes to the master that did not own the previous cycle.
          gnt_idx_d = (&m_cyc_i) ? ~last_q : m_cyc_i[1];
        end
      end

      StGnt: begin
        gnt_o     = gnt_oh;
        s_cyc_o   = m_cyc_i[gnt_idx_q];
        s_stb_o   = m_stb_i[gnt_idx_q] && !full;
        s_we_o    = m_we_i[gnt_idx_q];
        s_adr_o   = gnt_idx_q ? m_adr_i[2*ADDRBITS-1 -: ADDRBITS] : m_adr_i[ADDRBITS-1:0];
        s_dat_o   = gnt_idx_q ? m_dat_i[2*DATABITS-1 -: DATABITS] : m_dat_i[DATABITS-1:0];
        m_stall_o = ~gnt_oh | ((s_stall_i || full) ? gnt_oh : 2'b00);
        expire    = busy && !resp && (timer_q == TmrLast);
        m_ack_o   = (s_ack_i && busy) ? gnt_oh : 2'b00;
        m_err_o   = ((s_err_i && busy) || expire) ? gnt_oh : 2'b00;
        timeout_o = expire;
        accept    = s_stb_o && !s_stall_i;
        dec       = resp && busy;
        if (!m_cyc_i[gnt_idx_q]) begin
          // Release abandons anything still outstanding; late acks become spurious.
          state_d    = StIdle;
          last_d     = gnt_idx_q;
          inflight_d = '0;
        end else if (expire) begin
          state_d    = StAbort;
          inflight_d = '0;
        end else begin
          inflight_d = inflight_q + CntW'(accept) - CntW'(dec);
        end
      end

      StAbort: begin
        gnt_o = gnt_oh;
        if (!m_cyc_i[gnt_idx_q]) begin
          state_d = StIdle;
          last_d  = gnt_idx_q;
        end
      end

      default: state_d = StIdle;
    endcase

    spurious_o = resp && !busy;

    // Silence timer only runs while something is outstanding and the slave says nothing.
    if (resp || !busy || (inflight_d == '0)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TmrW'(1);
    end

    // Keep the slave and masters quiet while reset is held.
    if (!reset_ni) begin
      m_stall_o  = 2'b11;
      m_ack_o    = 2'b00;
      m_err_o    = 2'b00;
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_adr_o    = '0;
      s_dat_o    = '0;
      gnt_o      = 2'b00;
      timeout_o  = 1'b0;
      spurious_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      gnt_idx_q  <= 1'b0;
      last_q     <= 1'b1;
      inflight_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
      timer_q    <= timer_d;
    end
  end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Bench for wb_flash_arbiter: directed stimulus, a behavioural model of ownership,
// outstanding count and silence time, a per-cycle compare process, and literal
// expectations for each scenario.
module tb_wb_flash_arbiter;

  localparam int AB   = 26;
  localparam int DB   = 16;
  localparam int MAXF = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [2*AB-1:0] m_adr;
  logic [2*DB-1:0] m_dat;
  logic [1:0]    m_stall, m_ack, m_err;
  logic [DB-1:0] m_rdat;
  logic          s_cyc, s_stb, s_we;
  logic [AB-1:0] s_adr;
  logic [DB-1:0] s_wdat;
  logic          s_ack, s_err, s_stall;
  logic [DB-1:0] s_dat;
  logic [1:0]    gnt;
  logic          timeout, spurious;

  // Slave-side stimulus: either a fixed-latency (3) responder or forced values.
  logic       slave_auto = 1'b0;
  logic       ack_force = 1'b0;
  logic       err_force = 1'b0;
  logic [2:0] ack_pipe = 3'b000;
  logic [11:0] dcnt = 12'h000;

  assign s_ack = slave_auto ? ack_pipe[2] : ack_force;
  assign s_err = err_force;
  assign s_dat = {4'hC, dcnt};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ack_pipe <= {ack_pipe[1:0], s_cyc && s_stb && !s_stall};
    dcnt     <= dcnt + 12'h001;
  end

  wb_flash_arbiter #(
    .ADDRBITS   (AB),
    .DATABITS   (DB),
    .MAXINFLIGHT(MAXF),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_stall_o (m_stall),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_dat_o   (m_rdat),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_wdat),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .s_stall_i (s_stall),
    .s_dat_i   (s_dat),
    .gnt_o     (gnt),
    .timeout_o (timeout),
    .spurious_o(spurious)
  );

  // ---------------- behavioural model ----------------
  int owner   = -1;  // master owning the bus, -1 when none
  bit aborted = 1'b0;
  int pend    = 0;   // accepted requests not yet answered
  int silent  = 0;   // cycles with requests outstanding and no answer
  int last    = 1;

  logic [1:0]    e_gnt, e_stall, e_ack, e_err;
  logic          e_scyc, e_sstb, e_swe, e_to, e_spur;
  logic [AB-1:0] e_adr;
  logic [DB-1:0] e_wdat;
  logic          resp;

  assign resp = s_ack | s_err;

  always_comb begin
    e_gnt = 2'b00; e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00;
    e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_to = 1'b0; e_spur = 1'b0;
    e_adr = '0; e_wdat = '0;
    if (reset_n === 1'b1) begin
      e_spur = resp && (pend == 0);
      if (owner >= 0) begin
        e_gnt = 2'b01 << owner;
        if (!aborted) begin
          e_scyc         = m_cyc[owner];
          e_sstb         = m_stb[owner] && (pend < MAXF);
          e_swe          = m_we[owner];
          e_adr          = m_adr[owner*AB +: AB];
          e_wdat         = m_dat[owner*DB +: DB];
          e_stall[owner] = s_stall || (pend == MAXF);
          e_ack[owner]   = s_ack && (pend > 0);
          e_to           = (pend > 0) && !resp && (silent == TMO - 1);
          e_err[owner]   = (s_err && (pend > 0)) || e_to;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n !== 1'b1) begin
      owner <= -1; aborted <= 1'b0; pend <= 0; silent <= 0; last <= 1;
    end else begin
      if (owner < 0) begin
        if (m_cyc == 2'b11)  owner <= 1 - last;
        else if (m_cyc[0])   owner <= 0;
        else if (m_cyc[1])   owner <= 1;
      end else if (!m_cyc[owner]) begin
        owner <= -1; aborted <= 1'b0; last <= owner; pend <= 0;
      end else if (!aborted && e_to) begin
        aborted <= 1'b1; pend <= 0;
      end else if (!aborted) begin
        pend <= pend + ((e_sstb && !s_stall) ? 1 : 0) - ((resp && pend > 0) ? 1 : 0);
      end
      if (resp || pend == 0 || e_to || (owner >= 0 && !m_cyc[owner]))
        silent <= 0;
      else
        silent <= silent + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int n_ack0, n_ack1, n_sacc, n_spur, pend_max;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("gnt_o", 64'(gnt), 64'(e_gnt));
      check("s_cyc_o", 64'(s_cyc), 64'(e_scyc));
      check("s_stb_o", 64'(s_stb), 64'(e_sstb));
      check("s_we_o", 64'(s_we), 64'(e_swe));
      check("s_adr_o", 64'(s_adr), 64'(e_adr));
      check("s_dat_o", 64'(s_wdat), 64'(e_wdat));
      check("m_stall_o", 64'(m_stall), 64'(e_stall));
      check("m_ack_o", 64'(m_ack), 64'(e_ack));
      check("m_err_o", 64'(m_err), 64'(e_err));
      check("m_dat_o", 64'(m_rdat), 64'(s_dat));
      check("timeout_o", 64'(timeout), 64'(e_to));
      check("spurious_o", 64'(spurious), 64'(e_spur));
      if (m_ack[0] === 1'b1) n_ack0++;
      if (m_ack[1] === 1'b1) n_ack1++;
      if (s_cyc && s_stb && !s_stall) n_sacc++;
      if (spurious === 1'b1) n_spur++;
      if (pend > pend_max) pend_max = pend;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    n_ack0 = 0; n_ack1 = 0; n_sacc = 0; n_spur = 0; pend_max = 0;
  endtask

  // Waits (bounded) for master m's held STB to be taken; returns one cycle later.
  task automatic wait_accept(input int m, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (m_stall[m] === 1'b0) ok = 1'b1;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    bit ok;
    bit found;
    int n;
    reset_n = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    m_adr = {26'h3ABCDEF, 26'h0123456};
    m_dat = {16'hBEEF, 16'h1234};
    s_stall = 1'b0;
    clr_counts();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_scyc", 64'(s_cyc), 64'h0);
    check("rst_stall", 64'(m_stall), 64'h3);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: four pipelined reads by m0, slave latency 3
    clr_counts();
    slave_auto = 1'b1;
    m_cyc = 2'b01;
    for (int k = 0; k < 4; k++) begin
      m_stb[0] = 1'b1;
      m_adr[AB-1:0] = 26'h0100000 + 26'(k);
      wait_accept(0, ok);
      check("t1_accept", 64'(ok), 64'h1);
    end
    m_stb[0] = 1'b0;
    for (int i = 0; i < 20 && n_ack0 < 4; i++) tick();
    check("t1_acks_m0", 64'(n_ack0), 64'd4);
    check("t1_acks_m1", 64'(n_ack1), 64'd0);
    check("t1_peak", 64'(pend_max), 64'd3);
    check("t1_pend_end", 64'(pend), 64'd0);
    m_cyc = 2'b00;
    tick(); tick();
    slave_auto = 1'b0;

    // 2: simultaneous request after reset, then handover; m1 write under slave stall
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clr_counts();
    m_cyc = 2'b11;
    tick();
    @(negedge clk);
    check("t2_first_gnt", 64'(gnt), 64'h1);
    tick();
    m_cyc = 2'b10;
    tick();
    @(negedge clk);
    check("t2_idle_gnt", 64'(gnt), 64'h0);
    tick();
    m_stb[1] = 1'b1; m_we[1] = 1'b1; s_stall = 1'b1;
    @(negedge clk);
    check("t2_second_gnt", 64'(gnt), 64'h2);
    check("t2_stall_both", 64'(m_stall), 64'h3);
    tick(); tick();
    s_stall = 1'b0;
    wait_accept(1, ok);
    check("t2_accept_m1", 64'(ok), 64'h1);
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    tick(); tick();

    // 3: depth limit with a silent slave
    clr_counts();
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("t3_stall_full", 64'(m_stall[0]), 64'h1);
        check("t3_stb_gated", 64'(s_stb), 64'h0);
      end
      tick();
    end
    check("t3_accepted", 64'(n_sacc), 64'd4);
    m_cyc = 2'b00; m_stb = 2'b00;
    tick(); tick();

    // 4: timeout abort after one accepted request
    clr_counts();
    m_cyc = 2'b01; m_stb = 2'b01;
    wait_accept(0, ok);
    check("t4_accept", 64'(ok), 64'h1);
    m_stb = 2'b00;
    n = 1; found = 1'b0;
    while (!found && n < 20) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        found = 1'b1;
        check("t4_err", 64'(m_err), 64'h1);
      end else begin
        tick();
        n++;
      end
    end
    check("t4_found", 64'(found), 64'h1);
    check("t4_delay", 64'(n), 64'd8);
    tick();
    ack_force = 1'b1;
    @(negedge clk);
    check("t4_abort_cyc", 64'(s_cyc), 64'h0);
    check("t4_abort_gnt", 64'(gnt), 64'h1);
    check("t4_abort_spur", 64'(spurious), 64'h1);
    check("t4_abort_noack", 64'(m_ack), 64'h0);
    tick();
    ack_force = 1'b0;
    tick();
    m_cyc = 2'b00;
    tick();
    @(negedge clk);
    check("t4_idle_gnt", 64'(gnt), 64'h0);
    tick();

    // 5: ack arriving after release is spurious
    clr_counts();
    slave_auto = 1'b1;
    m_cyc = 2'b01; m_stb = 2'b01;
    wait_accept(0, ok);
    check("t5_accept", 64'(ok), 64'h1);
    m_cyc = 2'b00; m_stb = 2'b00;
    repeat (6) tick();
    check("t5_spur_count", 64'(n_spur), 64'd1);
    check("t5_no_ack", 64'(n_ack0), 64'd0);
    check("t5_pend", 64'(pend), 64'd0);
    slave_auto = 1'b0;

    // 6: reset mid-burst with three outstanding
    clr_counts();
    m_cyc = 2'b01; m_stb = 2'b01;
    for (int k = 0; k < 3; k++) wait_accept(0, ok);
    m_stb = 2'b00;
    check("t6_accepted", 64'(n_sacc), 64'd3);
    check("t6_pend", 64'(pend), 64'd3);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_cyc", 64'(s_cyc), 64'h0);
    tick();
    reset_n = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    check("t6_gnt", 64'(gnt), 64'h0);
    check("t6_cyc", 64'(s_cyc), 64'h0);
    check("t6_spur_empty", 64'(spurious), 64'h1);
    check("t6_model_pend", 64'(pend), 64'd0);
    tick();
    ack_force = 1'b0;
    m_cyc = 2'b00;
    tick(); tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
